// File: rtl/flag_detector.sv
// Status-flag generator placed after the ALU result mux: registered signed-overflow
// and zero flags, plus a sticky overflow flag that software or the controller polls.
module flag_detector #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_overflow,
  input  logic [WIDTH-1:0] result,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             sign_result,
  input  logic             sel_sub,
  input  logic             sticky_clear,
  output logic             overflow,
  output logic             zero,
  output logic             sticky_overflow
);

  logic ovf_n;
  logic zero_n;
  logic operands_allow_ovf;

  // Subtraction inverts B's effective sign, so overflow needs the opposite sign relation.
  always_comb begin
    operands_allow_ovf = sel_sub ? (sign_a != sign_b) : (sign_a == sign_b);
    ovf_n              = enable_overflow & operands_allow_ovf & (sign_result != sign_a);
    zero_n             = (result == '0);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow        <= 1'b0;
      zero            <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      overflow        <= ovf_n;
      zero            <= zero_n;
      // A new overflow in the same cycle as a clear must still be recorded.
      sticky_overflow <= (sticky_clear ? 1'b0 : sticky_overflow) | ovf_n;
    end
  end

endmodule

// File: tb/tb_flag_detector.sv
// Self-checking bench for flag_detector: directed steps from the test plan, then
// random add/sub operations scored against real signed arithmetic.
module tb_flag_detector;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable_overflow;
  logic [WIDTH-1:0] result;
  logic             sign_a;
  logic             sign_b;
  logic             sign_result;
  logic             sel_sub;
  logic             sticky_clear;
  logic             overflow;
  logic             zero;
  logic             sticky_overflow;

  int checks   = 0;
  int failures = 0;

  flag_detector #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_overflow (enable_overflow),
    .result          (result),
    .sign_a          (sign_a),
    .sign_b          (sign_b),
    .sign_result     (sign_result),
    .sel_sub         (sel_sub),
    .sticky_clear    (sticky_clear),
    .overflow        (overflow),
    .zero            (zero),
    .sticky_overflow (sticky_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ovf, input logic e_zero,
                           input logic e_sticky);
    check({tag, ".overflow"}, overflow, e_ovf);
    check({tag, ".zero"}, zero, e_zero);
    check({tag, ".sticky"}, sticky_overflow, e_sticky);
  endtask

  // Drive one operation, let it cross a rising edge, sample 1 time unit later.
  task automatic apply(input logic en, input logic sub, input logic sa, input logic sb,
                       input logic sr, input logic [WIDTH-1:0] res, input logic clr);
    enable_overflow = en;
    sel_sub         = sub;
    sign_a          = sa;
    sign_b          = sb;
    sign_result     = sr;
    result          = res;
    sticky_clear    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b, r;
    logic             en, sub, clr;
    longint           wide;
    logic             ovf_ref, sticky_ref;

    // Reset with every other input high: outputs must clear before any clock edge.
    rst_n = 1'b0;
    enable_overflow = 1'b1; sel_sub = 1'b1; sign_a = 1'b1; sign_b = 1'b1;
    sign_result = 1'b1; sticky_clear = 1'b1; result = '0;
    #2;
    check_all("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(1, 0, 0, 0, 1, 32'h8000_0000, 0);
    check_all("add_ovf", 1'b1, 1'b0, 1'b1);
    apply(1, 0, 0, 1, 1, 32'h8000_0000, 0);
    check_all("add_mixed", 1'b0, 1'b0, 1'b1);
    apply(1, 1, 1, 0, 0, 32'h7FFF_FFFF, 0);
    check_all("sub_ovf", 1'b1, 1'b0, 1'b1);
    apply(1, 1, 1, 1, 0, 32'h7FFF_FFFF, 0);
    check_all("sub_same", 1'b0, 1'b0, 1'b1);

    apply(0, 0, 0, 0, 0, 32'h0000_0005, 1);
    check_all("clear", 1'b0, 1'b0, 1'b0);
    apply(0, 0, 0, 0, 1, 32'h8000_0000, 0);
    check_all("gated", 1'b0, 1'b0, 1'b0);

    apply(0, 0, 0, 0, 0, 32'h0000_0000, 0);
    check_all("zero_all0", 1'b0, 1'b1, 1'b0);
    apply(0, 0, 0, 0, 0, 32'h0000_0001, 0);
    check_all("zero_lsb", 1'b0, 1'b0, 1'b0);
    apply(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    check_all("zero_all1", 1'b0, 1'b0, 1'b0);
    // Zero flag must also work while overflow checking is active.
    apply(1, 1, 0, 0, 0, 32'h0000_0000, 0);
    check_all("zero_arith", 1'b0, 1'b1, 1'b0);

    apply(1, 0, 1, 1, 0, 32'h0000_0000, 0);
    check_all("sticky_set", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 1, 1, 32'h0000_1234, 0);
      check_all($sformatf("sticky_hold%0d", i), 1'b0, 1'b0, 1'b1);
    end
    apply(1, 0, 0, 0, 0, 32'h0000_0010, 1);
    check_all("sticky_clr", 1'b0, 1'b0, 1'b0);
    apply(1, 0, 0, 0, 1, 32'h8000_0000, 1);
    check_all("clr_and_set", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle drops the sticky history at once.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("held_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random operations: overflow means the true signed result does not fit WIDTH bits.
    sticky_ref = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a   = $urandom;
      b   = $urandom;
      sub = $urandom_range(0, 1);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) b = sub ? a : (0 - a);
      if ($urandom_range(0, 5) == 0) begin
        a = {1'b0, {(WIDTH-1){1'b1}}};
        b = sub ? {1'b1, {(WIDTH-1){1'b1}}} : 1;
      end
      r    = sub ? (a - b) : (a + b);
      wide = sub ? (longint'(signed'(a)) - longint'(signed'(b)))
                 : (longint'(signed'(a)) + longint'(signed'(b)));
      ovf_ref    = en && (wide != longint'(signed'(r)));
      sticky_ref = (clr ? 1'b0 : sticky_ref) | ovf_ref;
      apply(en, sub, a[WIDTH-1], b[WIDTH-1], r[WIDTH-1], r, clr);
      check_all($sformatf("rand%0d", i), ovf_ref, (r == '0), sticky_ref);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_detector.md
Name: flag_detector

Overview:
- Status-flag generator for the 32-bit ALU datapath.
- Takes the ALU result and operand/result sign bits and produces signed-overflow and zero flags, registered on the system clock.
- Also keeps a sticky overflow flag for software/controller polling.
- Sits directly after the ALU result mux; the ALU enables overflow checking only for arithmetic opcodes.

Parameters:
- WIDTH, 32, width of the result word checked for zero.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- enable_overflow  input  1  1 = current operation is arithmetic; overflow evaluation enabled.
- result  input  WIDTH  ALU result word.
- sign_a  input  1  MSB of operand A.
- sign_b  input  1  MSB of operand B.
- sign_result  input  1  MSB of result.
- sel_sub  input  1  0 = addition-class op, 1 = subtraction-class op.
- sticky_clear  input  1  synchronous clear of the sticky overflow flag.
- overflow  output  1  registered signed-overflow flag for the current operation.
- zero  output  1  registered zero flag.
- sticky_overflow  output  1  set on any overflow; held until cleared.

Behaviour:
- Reset (rst_n=0, asynchronous): overflow=0, zero=0, sticky_overflow=0. Outputs hold these values until the first rising clk after rst_n deasserts.
- Combinational next-overflow, addition (sel_sub=0): ovf_n = enable_overflow & (sign_a == sign_b) & (sign_result != sign_a).
- Combinational next-overflow, subtraction (sel_sub=1): ovf_n = enable_overflow & (sign_a != sign_b) & (sign_result != sign_a).
- enable_overflow=0 forces ovf_n=0 regardless of signs and sel_sub.
- Zero: zero_n = (result == 0) over all WIDTH bits. It is independent of enable_overflow and evaluated for logical, shift and arithmetic results alike.
- Latency: overflow and zero update on every rising clk edge, exactly 1 cycle after their inputs. There is no enable and no hold.
- Sticky flag: on each rising edge, sticky_overflow <= (sticky_clear ? 0 : sticky_overflow) | ovf_n.
  - Simultaneous sticky_clear=1 and ovf_n=1: set wins, so sticky_overflow=1.
- Inputs are sampled only at clk edges; glitches between edges have no effect.
- Reset asserted mid-operation clears all three outputs immediately; the sticky history is lost.
- sign_result is used as given; it is not derived from result[WIDTH-1]. The parent guarantees consistency.
- No X-propagation masking. All outputs are driven at all times after reset.

Test Plan:
- Reset: rst_n=0 with result=0 and all other inputs 1 -> overflow=0, zero=0, sticky_overflow=0 immediately, without waiting for a clk edge.
- Add overflow: enable_overflow=1, sel_sub=0, sign_a=0, sign_b=0, sign_result=1, result=32'h8000_0000 -> next cycle overflow=1, zero=0, sticky_overflow=1. Repeat with sign_a=0, sign_b=1 -> overflow=0.
- Sub overflow: enable_overflow=1, sel_sub=1, sign_a=1, sign_b=0, sign_result=0, result=32'h7FFF_FFFF -> overflow=1. Repeat with sign_b=1 -> overflow=0.
- Overflow gating: enable_overflow=0, sel_sub=0, sign_a=0, sign_b=0, sign_result=1 -> overflow=0 and sticky_overflow unchanged.
- Zero: result=32'h0000_0000 with enable_overflow=0 -> zero=1 next cycle. Then result=32'h0000_0001 -> zero=0. Also cover result=32'hFFFF_FFFF -> zero=0.
- Sticky: cause one overflow, then drive non-overflow ops for 5 cycles -> sticky_overflow stays 1. Then sticky_clear=1 with no overflow -> sticky_overflow=0 next cycle. Then sticky_clear=1 together with an add overflow -> sticky_overflow=1.
